// File: rtl/snake_grid_renderer.sv
// Snake game cell-occupancy map: 16x16 map of 2-bit codes kept in sync with head/tail/apple moves,
// with an independent registered scan read port. Optional head blink while dead: define DEAD_FLASH_EN.
module snake_grid_renderer #(
  parameter int INIT_HEAD_X  = 4,
  parameter int INIT_HEAD_Y  = 7,
  parameter int INIT_APPLE_X = 11,
  parameter int INIT_APPLE_Y = 7,
  parameter int BLINK_BITS   = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd_valid,
  input  logic [3:0] head_x,
  input  logic [3:0] head_y,
  input  logic [3:0] tail_x,
  input  logic [3:0] tail_y,
  input  logic [3:0] apple_x,
  input  logic [3:0] apple_y,
  input  logic [1:0] game_state,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output logic [1:0] rd_code,
  output logic       ready,
  output logic       busy,
  output logic       dead,
  output logic [7:0] score,
  output logic       overflow
);

  localparam logic [1:0] CODE_EMPTY = 2'b00;
  localparam logic [1:0] CODE_BODY  = 2'b01;
  localparam logic [1:0] CODE_HEAD  = 2'b10;
  localparam logic [1:0] CODE_APPLE = 2'b11;
  localparam logic [1:0] ST_DEAD    = 2'b10;

  localparam logic [7:0] INIT_HEAD  = {4'(INIT_HEAD_Y), 4'(INIT_HEAD_X)};
  localparam logic [7:0] INIT_BODY0 = {4'(INIT_HEAD_Y), 4'(INIT_HEAD_X - 2)};
  localparam logic [7:0] INIT_BODY1 = {4'(INIT_HEAD_Y), 4'(INIT_HEAD_X - 1)};
  localparam logic [7:0] INIT_APPLE = {4'(INIT_APPLE_Y), 4'(INIT_APPLE_X)};

  typedef enum logic [3:0] {
    CLEAR, INIT0, INIT1, INIT2, INIT3, IDLE, WR_BODY, WR_HEAD, WR_TAIL, WR_APPLE
  } state_t;

  state_t     state, state_next;
  logic [1:0] mem [0:255];
  logic [7:0] clr_addr;
  logic [7:0] prev_head, prev_tail, prev_apple;
  logic [7:0] lat_head, lat_tail, lat_apple;
  logic       pend_valid;
  logic [7:0] pend_head, pend_tail, pend_apple;
  logic [1:0] pend_state;

  logic       we;
  logic [7:0] waddr;
  logic [1:0] wdata;
  logic       lat_load, set_dead, pend_load, pend_clr, set_ovf, finish, score_inc;
  logic       tail_do, apple_do;
  logic       req_valid;
  logic [7:0] req_head, req_tail, req_apple;
  logic [1:0] req_state;
  logic [1:0] stored_code;

  // A waiting pending update takes priority over a fresh strobe in IDLE.
  assign req_valid = pend_valid | upd_valid;
  assign req_head  = pend_valid ? pend_head  : {head_y, head_x};
  assign req_tail  = pend_valid ? pend_tail  : {tail_y, tail_x};
  assign req_apple = pend_valid ? pend_apple : {apple_y, apple_x};
  assign req_state = pend_valid ? pend_state : game_state;

  assign tail_do  = (lat_tail != prev_tail) && (prev_tail != lat_head);
  assign apple_do = (lat_apple != prev_apple);

  // Next-state, write port and bookkeeping strobes.
  always_comb begin
    state_next = state;
    we         = 1'b0;
    waddr      = 8'h00;
    wdata      = CODE_EMPTY;
    lat_load   = 1'b0;
    set_dead   = 1'b0;
    pend_load  = 1'b0;
    pend_clr   = 1'b0;
    set_ovf    = 1'b0;
    finish     = 1'b0;
    score_inc  = 1'b0;
    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_addr;
        if (clr_addr == 8'hFF) state_next = INIT0;
        else                   state_next = CLEAR;
      end
      INIT0: begin we = 1'b1; waddr = INIT_BODY0; wdata = CODE_BODY;  state_next = INIT1; end
      INIT1: begin we = 1'b1; waddr = INIT_BODY1; wdata = CODE_BODY;  state_next = INIT2; end
      INIT2: begin we = 1'b1; waddr = INIT_HEAD;  wdata = CODE_HEAD;  state_next = INIT3; end
      INIT3: begin we = 1'b1; waddr = INIT_APPLE; wdata = CODE_APPLE; state_next = IDLE;  end
      IDLE: begin
        if (!dead && req_valid) begin
          if (req_state == ST_DEAD) begin
            set_dead = 1'b1;
            pend_clr = 1'b1;
          end else begin
            if (req_head != prev_head) begin
              lat_load   = 1'b1;
              state_next = WR_BODY;
            end else begin
              state_next = IDLE;
            end
            // Consuming the pending slot frees it for a strobe arriving this same cycle.
            if (pend_valid) begin
              pend_load = upd_valid;
              pend_clr  = ~upd_valid;
            end else begin
              pend_load = 1'b0;
            end
          end
        end else begin
          state_next = IDLE;
        end
      end
      WR_BODY: begin
        we = 1'b1; waddr = prev_head; wdata = CODE_BODY;
        state_next = WR_HEAD;
      end
      WR_HEAD: begin
        we = 1'b1; waddr = lat_head; wdata = CODE_HEAD;
        if (tail_do)       state_next = WR_TAIL;
        else if (apple_do) state_next = WR_APPLE;
        else begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
      WR_TAIL: begin
        we = 1'b1; waddr = prev_tail; wdata = CODE_EMPTY;
        if (apple_do) state_next = WR_APPLE;
        else begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
      WR_APPLE: begin
        we = 1'b1; waddr = lat_apple; wdata = CODE_APPLE;
        score_inc  = 1'b1;
        state_next = IDLE;
        finish     = 1'b1;
      end
      default: state_next = CLEAR;
    endcase
    if (state inside {WR_BODY, WR_HEAD, WR_TAIL, WR_APPLE} && upd_valid) begin
      if (pend_valid) set_ovf   = 1'b1;
      else            pend_load = 1'b1;
    end else begin
      set_ovf = 1'b0;
    end
  end

  // FSM state, clear counter and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= 8'h00;
      ready    <= 1'b0;
      busy     <= 1'b1;
      dead     <= 1'b0;
      score    <= 8'h00;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      clr_addr <= (state == CLEAR) ? clr_addr + 8'h01 : clr_addr;
      ready    <= ready | (state == INIT3);
      busy     <= (state_next != IDLE);
      dead     <= dead | set_dead;
      overflow <= overflow | set_ovf;
      if (score_inc && score != 8'hFF) score <= score + 8'h01;
    end
  end

  // Previous/latched positions and the one-deep pending buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_head  <= INIT_HEAD;
      prev_tail  <= INIT_BODY0;
      prev_apple <= INIT_APPLE;
      lat_head   <= 8'h00;
      lat_tail   <= 8'h00;
      lat_apple  <= 8'h00;
      pend_valid <= 1'b0;
      pend_head  <= 8'h00;
      pend_tail  <= 8'h00;
      pend_apple <= 8'h00;
      pend_state <= 2'b00;
    end else begin
      if (state == INIT3) begin
        prev_head  <= INIT_HEAD;
        prev_tail  <= INIT_BODY0;
        prev_apple <= INIT_APPLE;
      end else if (finish) begin
        prev_head  <= lat_head;
        prev_tail  <= lat_tail;
        prev_apple <= lat_apple;
      end
      if (lat_load) begin
        lat_head  <= req_head;
        lat_tail  <= req_tail;
        lat_apple <= req_apple;
      end
      if (pend_load) begin
        pend_valid <= 1'b1;
        pend_head  <= {head_y, head_x};
        pend_tail  <= {tail_y, tail_x};
        pend_apple <= {apple_y, apple_x};
        pend_state <= game_state;
      end else if (pend_clr) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Map storage write port.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[waddr] <= wdata;
  end

  assign stored_code = mem[{rd_y, rd_x}];

`ifdef DEAD_FLASH_EN
  logic [BLINK_BITS-1:0] blink;

  // Free-running blink divider.
  always_ff @(posedge clk) begin
    if (rst) blink <= '0;
    else     blink <= blink + 1'b1;
  end

  // Registered read; head hidden during the blink-off phase while dead.
  always_ff @(posedge clk) begin
    if (rst) rd_code <= CODE_EMPTY;
    else if (dead && blink[BLINK_BITS-1] && stored_code == CODE_HEAD) rd_code <= CODE_EMPTY;
    else rd_code <= stored_code;
  end
`else
  // Registered read; read-first against a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) rd_code <= CODE_EMPTY;
    else     rd_code <= stored_code;
  end
`endif

endmodule

// File: tb/tb_snake_grid_renderer.sv
// Self-checking bench for snake_grid_renderer: directed scenarios plus random moves against a grid model.
module tb_snake_grid_renderer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       upd_valid = 1'b0;
  logic [3:0] head_x = 4'd0, head_y = 4'd0, tail_x = 4'd0, tail_y = 4'd0;
  logic [3:0] apple_x = 4'd0, apple_y = 4'd0, rd_x = 4'd0, rd_y = 4'd0;
  logic [1:0] game_state = 2'b00;
  logic [1:0] rd_code;
  logic       ready, busy, dead, overflow;
  logic [7:0] score;

  int nasrt = 0;
  int nfail = 0;

  // Reference model: grid[y][x] plus the snake's remembered cells.
  logic [1:0] grid [0:15][0:15];
  logic [3:0] m_hx, m_hy, m_tx, m_ty, m_ax, m_ay;
  logic       m_dead, m_ovf;
  int         m_score;

  snake_grid_renderer dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid),
    .head_x(head_x), .head_y(head_y), .tail_x(tail_x), .tail_y(tail_y),
    .apple_x(apple_x), .apple_y(apple_y), .game_state(game_state),
    .rd_x(rd_x), .rd_y(rd_y), .rd_code(rd_code), .ready(ready), .busy(busy),
    .dead(dead), .score(score), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) grid[y][x] = 2'b00;
    grid[7][2] = 2'b01; grid[7][3] = 2'b01; grid[7][4] = 2'b10; grid[7][11] = 2'b11;
    m_hx = 4'd4; m_hy = 4'd7; m_tx = 4'd2; m_ty = 4'd7; m_ax = 4'd11; m_ay = 4'd7;
    m_dead = 1'b0; m_ovf = 1'b0; m_score = 0;
  endtask

  // Applies one move by the game rules; returns how many cells get written.
  task automatic model_move(input logic [3:0] hx, hy, tx, ty, ax, ay, input logic [1:0] st,
                            output int writes);
    writes = 0;
    if (m_dead) return;
    if (st == 2'b10) begin m_dead = 1'b1; return; end
    if (hx == m_hx && hy == m_hy) return;
    grid[m_hy][m_hx] = 2'b01;
    grid[hy][hx] = 2'b10;
    writes = 2;
    if (!(tx == m_tx && ty == m_ty) && !(m_tx == hx && m_ty == hy)) begin
      grid[m_ty][m_tx] = 2'b00;
      writes++;
    end
    if (!(ax == m_ax && ay == m_ay)) begin
      grid[ay][ax] = 2'b11;
      writes++;
      if (m_score < 255) m_score++;
    end
    m_hx = hx; m_hy = hy; m_tx = tx; m_ty = ty; m_ax = ax; m_ay = ay;
  endtask

  task automatic strobe(input logic [3:0] hx, hy, tx, ty, ax, ay, input logic [1:0] st);
    head_x = hx; head_y = hy; tail_x = tx; tail_y = ty;
    apple_x = ax; apple_y = ay; game_state = st; upd_valid = 1'b1;
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic settle(input string tag);
    int low = 0;
    for (int c = 0; c < 60 && low < 3; c++) begin
      @(posedge clk); #1;
      low = busy ? 0 : low + 1;
    end
    chk(tag, low >= 3, 1);
  endtask

  task automatic check_map(input string tag);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        rd_x = 4'(x); rd_y = 4'(y);
        @(posedge clk); #1;
        chk($sformatf("%s map(%0d,%0d)", tag, x, y), rd_code, grid[y][x]);
      end
  endtask

  task automatic check_status(input string tag);
    chk({tag, " score"}, score, m_score);
    chk({tag, " dead"}, dead, m_dead);
    chk({tag, " overflow"}, overflow, m_ovf);
  endtask

  task automatic wait_ready(input string tag);
    int c = 0;
    while (!ready && c < 400) begin @(posedge clk); #1; c++; end
    chk(tag, ready, 1);
  endtask

  task automatic rand_move(output logic [3:0] hx, hy, tx, ty, ax, ay);
    hx = 4'($urandom_range(15)); hy = 4'($urandom_range(15));
    if ($urandom_range(7) == 0) begin hx = m_hx; hy = m_hy; end
    if ($urandom_range(2) == 0) begin tx = m_tx; ty = m_ty; end
    else begin tx = 4'($urandom_range(15)); ty = 4'($urandom_range(15)); end
    if ($urandom_range(1) == 0) begin ax = m_ax; ay = m_ay; end
    else begin ax = 4'($urandom_range(15)); ay = 4'($urandom_range(15)); end
  endtask

  initial begin
    logic [3:0] hx, hy, tx, ty, ax, ay, hx2, hy2, tx2, ty2, ax2, ay2;
    int w, bcnt;

    // Reset values while rst is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst rd_code", rd_code, 2'b00);
    chk("rst ready", ready, 0);
    chk("rst busy", busy, 1);
    chk("rst dead", dead, 0);
    chk("rst score", score, 0);
    chk("rst overflow", overflow, 0);

    // Ready timing; a strobe during CLEAR must be ignored.
    model_reset();
    rst = 1'b0;
    head_x = 4'd9; head_y = 4'd9; game_state = 2'b00;
    for (int i = 1; i <= 260; i++) begin
      upd_valid = (i == 100);
      @(posedge clk); #1;
      if (i == 259) chk("ready before 260", ready, 0);
      if (i == 260) chk("ready at 260", ready, 1);
    end
    upd_valid = 1'b0;
    chk("init busy", busy, 0);
    check_map("init");
    check_status("init");

    // Normal move, busy length follows the write count.
    model_move(4'd5, 4'd7, 4'd3, 4'd7, 4'd11, 4'd7, 2'b00, w);
    strobe(4'd5, 4'd7, 4'd3, 4'd7, 4'd11, 4'd7, 2'b00);
    bcnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
    end
    chk("normal busy cycles", bcnt, w);
    check_map("normal");
    check_status("normal");

    // Eat: growth move with a new apple.
    model_move(4'd11, 4'd7, 4'd3, 4'd7, 4'd6, 4'd2, 2'b01, w);
    strobe(4'd11, 4'd7, 4'd3, 4'd7, 4'd6, 4'd2, 2'b01);
    settle("eat settle");
    check_map("eat");
    check_status("eat");

    // Back-to-back pair, both applied in order.
    rand_move(hx, hy, tx, ty, ax, ay);
    if (hx == m_hx && hy == m_hy) hx = hx + 4'd1;
    model_move(hx, hy, tx, ty, ax, ay, 2'b00, w);
    rand_move(hx2, hy2, tx2, ty2, ax2, ay2);
    model_move(hx2, hy2, tx2, ty2, ax2, ay2, 2'b01, w);
    strobe(hx, hy, tx, ty, ax, ay, 2'b00);
    strobe(hx2, hy2, tx2, ty2, ax2, ay2, 2'b01);
    settle("b2b settle");
    check_map("b2b");
    check_status("b2b");

    // Three strobes on consecutive cycles: the third finds the pending slot full.
    rand_move(hx, hy, tx, ty, ax, ay);
    if (hx == m_hx && hy == m_hy) hx = hx + 4'd1;
    model_move(hx, hy, tx, ty, ax, ay, 2'b00, w);
    rand_move(hx2, hy2, tx2, ty2, ax2, ay2);
    model_move(hx2, hy2, tx2, ty2, ax2, ay2, 2'b00, w);
    m_ovf = 1'b1;
    strobe(hx, hy, tx, ty, ax, ay, 2'b00);
    strobe(hx2, hy2, tx2, ty2, ax2, ay2, 2'b00);
    strobe(4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 2'b00);
    settle("ovf settle");
    check_map("ovf");
    check_status("ovf");

    // Random moves, each checked against the model.
    for (int n = 0; n < 20; n++) begin
      rand_move(hx, hy, tx, ty, ax, ay);
      model_move(hx, hy, tx, ty, ax, ay, 2'($urandom_range(1)), w);
      strobe(hx, hy, tx, ty, ax, ay, 2'b00);
      settle("rand settle");
      if (n % 5 == 4) check_map($sformatf("rand%0d", n));
      check_status("rand");
    end

    // Reset while the sequence is in its second write cycle.
    rand_move(hx, hy, tx, ty, ax, ay);
    if (hx == m_hx && hy == m_hy) hx = hx + 4'd1;
    strobe(hx, hy, tx, ty, ax, ay, 2'b00);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("midrst ready low", ready, 0);
    wait_ready("midrst ready");
    check_map("midrst");
    check_status("midrst");

    // Dead: map frozen, later strobes ignored.
    model_move(4'd5, 4'd7, 4'd3, 4'd7, 4'd11, 4'd7, 2'b10, w);
    strobe(4'd5, 4'd7, 4'd3, 4'd7, 4'd11, 4'd7, 2'b10);
    settle("dead settle");
    check_status("dead");
    model_move(4'd5, 4'd7, 4'd3, 4'd7, 4'd1, 4'd1, 2'b00, w);
    strobe(4'd5, 4'd7, 4'd3, 4'd7, 4'd1, 4'd1, 2'b00);
    settle("dead2 settle");
    check_map("dead");
    check_status("dead2");

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end

endmodule

// File: doc/snake_grid_renderer.md
Name: snake_grid_renderer

Overview:
- Consumer end of the game-body position interface.
- Takes head, tail and apple coordinates plus game state once per completed move, and keeps a 16x16 cell-occupancy map of 2-bit codes in sync with them.
- A VGA/LED scan engine reads the map through an independent read port.
- Also tracks an apple score counter and a dead flag.

Parameters:
- INIT_HEAD_X, 4, head column after reset (0-based).
- INIT_HEAD_Y, 7, head row after reset.
- INIT_APPLE_X, 11, apple column after reset.
- INIT_APPLE_Y, 7, apple row after reset.
- BLINK_BITS, 24, width of the dead-flash divider (only used with DEAD_FLASH_EN).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- upd_valid  in  1  one-cycle strobe; position/state inputs are stable for a completed move
- head_x, head_y  in  4 each  head cell
- tail_x, tail_y  in  4 each  current tail cell
- apple_x, apple_y  in  4 each  apple cell
- game_state  in  2  00 normal, 01 ate apple, 10 dead
- rd_x, rd_y  in  4 each  scan read address
- rd_code  out  2  cell code: 00 empty, 01 body, 10 head, 11 apple
- ready  out  1  map initialised; updates accepted
- busy  out  1  update sequence in progress
- dead  out  1  sticky game-over
- score  out  8  apples eaten, saturating
- overflow  out  1  sticky; an update was dropped

Behaviour:
- Map storage: 256x2, address = {y,x}. One write port, driven only by the FSM. One read port.
- Read port: rd_code registered, 1-cycle latency. Read-first: a same-address write in the same cycle returns the old code.
- Reset values: rd_code=00, ready=0, busy=1, dead=0, score=0, overflow=0, pending=0.
- Reset mid-operation aborts any sequence and restarts CLEAR.
- FSM states: CLEAR, INIT0..INIT3, IDLE, WR_BODY, WR_HEAD, WR_TAIL, WR_APPLE.
- CLEAR: writes 00 to addresses 0..255, one per cycle (256 cycles).
- INIT0..INIT3, in order:
  - (INIT_HEAD_X-2, INIT_HEAD_Y) = body
  - (INIT_HEAD_X-1, INIT_HEAD_Y) = body
  - head cell = head
  - apple cell = apple
- On leaving INIT3:
  - prev_head=(INIT_HEAD_X,INIT_HEAD_Y)
  - prev_tail=(INIT_HEAD_X-2,INIT_HEAD_Y)
  - prev_apple=(INIT_APPLE_X,INIT_APPLE_Y)
  - ready=1, busy=0
  - ready rises exactly 260 cycles after the first cycle with rst low.
- upd_valid before ready=1 is ignored. It does not set overflow.
- IDLE with upd_valid:
  - If game_state==10: set dead, no writes. While dead, all later upd_valid are ignored until rst.
  - Else, if head==prev_head: no writes.
  - Else: latch all inputs, busy=1, go to WR_BODY.
- WR_BODY: prev_head := body.
- WR_HEAD: latched head := head.
- WR_TAIL: only if tail!=prev_tail and prev_tail!=head. Writes prev_tail := empty. Otherwise the state is skipped (0 cycles).
- WR_APPLE: only if apple!=prev_apple. Writes apple := apple and score increments (saturates at 255). Otherwise skipped.
- End of sequence: prev_head/prev_tail/prev_apple take the latched values, busy=0, return to IDLE. Full sequence is 4 cycles max, 2 min.
- upd_valid while busy: latched into a one-deep pending buffer, serviced immediately after the current sequence. A further upd_valid while pending is full is dropped and sets overflow.
- Growth move (tail unchanged): no erase, snake lengthens by one.

Optional Feature:
- Macro: DEAD_FLASH_EN.
- Defined: a free-running BLINK_BITS counter is added. While dead=1 and the counter MSB=1, any head code read out is replaced by 00, so the head blinks.
- Not defined: no counter; rd_code is always the stored code.

Test Plan:
- Init: assert rst 1 cycle, release -> ready=1 at cycle 260. Reads give (2,7)=01, (3,7)=01, (4,7)=10, (11,7)=11, (0,0)=00, rd_code 1 cycle after address.
- Normal move: upd_valid with head=(5,7), tail=(3,7), apple=(11,7), state 00 -> (2,7)=00, (3,7)=01, (4,7)=01, (5,7)=10; busy high 3 cycles; score=0.
- Eat: head moves to (11,7), tail unchanged, apple=(6,2), state 01 -> (11,7)=10, old tail retained, (6,2)=11, score=1.
- Back-to-back: two upd_valid 1 cycle apart -> both applied in order, overflow=0. A third strobe during the first sequence -> overflow=1.
- Dead: upd_valid with state 10 -> dead=1, map unchanged. Later upd_valid with a new head -> ignored.
- Reset mid-sequence: rst during WR_HEAD -> map fully cleared and re-initialised, score=0, dead=0, overflow=0.
